mdr_fetch_ctrl: RTL
===================

Name: mdr_fetch_ctrl

Overview:
- Sequencer that assembles one 16-bit word in the memory data register from a 4-bit-wide memory.
- On request it issues four nibble reads at base, base+1, base+2, base+3.
- It waits a fixed memory latency for each read, then drives the MDR's one-hot nibble enable so each returned nibble lands in the correct slice. Nibble order is big-endian: base goes to [15:12].
- It sits between the CPU control unit (requester) and the memory/MDR pair, and reports completion with a one-cycle pulse.

Parameters:
- ADDR_W, 12, width of the nibble address.
- MEM_LAT, 1, cycles from the mem_rd cycle to the cycle data is valid on the memory bus. Legal range 1..7.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  1  fetch request, level; sampled only in IDLE.
- base_addr  input  ADDR_W  nibble address of the word's most-significant nibble; captured on acceptance.
- abort  input  1  synchronous cancel of an in-flight fetch.
- ack  output  1  combinational: (state==IDLE) & req & ~abort; marks the acceptance cycle.
- mem_rd  output  1  memory read strobe, one cycle per nibble.
- mem_addr  output  ADDR_W  memory nibble address; valid while mem_rd=1, holds last value otherwise.
- mdr_en  output  4  one-hot MDR nibble enable: 1000, 0100, 0010, 0001 for idx 0..3; 0000 otherwise.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the fourth nibble is latched.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, idx=0, latency counter=0, captured base=0.
  - mem_rd=0, mem_addr=0, mdr_en=0000, busy=0, done=0. ack=0 because req is ignored during reset.
  - Reset mid-fetch abandons the fetch immediately; no done is issued.
- State machine: IDLE, ISSUE, WAIT, LATCH, DONE. All outputs except ack are Moore (decoded from registered state, idx and base).
- IDLE:
  - If req & ~abort: ack=1, capture base_addr, idx<=0, next state ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_rd=1, mem_addr=(base+idx) mod 2^ADDR_W.
  - Load latency counter with MEM_LAT-1.
  - Next state is WAIT if MEM_LAT>1, else LATCH.
- WAIT:
  - Decrement the counter each cycle; go to LATCH when it reaches 1→0. This gives exactly MEM_LAT-1 WAIT cycles.
- LATCH:
  - mdr_en=one-hot(idx) for exactly this cycle, which is ISSUE cycle + MEM_LAT. The MDR samples at the closing edge.
  - If idx==3, next state DONE. Otherwise idx<=idx+1 and next state ISSUE.
- DONE: done=1, busy=1, next state IDLE.
- Timing:
  - Fetch length from the ack cycle to the done cycle is 4*(MEM_LAT+1)+1 cycles. For MEM_LAT=1, done comes 9 cycles after ack.
  - Minimum spacing of ack pulses with req held high is 4*(MEM_LAT+1)+2 cycles, because req seen during DONE is not accepted until the following IDLE cycle.
- abort:
  - In any non-IDLE state, the next state is IDLE and idx<=0; no done pulse.
  - Outputs of the abort cycle itself remain as decoded for the current state. An abort in LATCH still writes that nibble.
  - In IDLE, abort=1 blocks acceptance (ack=0) even if req=1.
- req, base_addr changes while busy are ignored. The captured base stays fixed for the whole fetch.
- Address wrap: base+idx wraps modulo 2^ADDR_W. No error is flagged.
- At most one bit of mdr_en is high in any cycle. mem_rd and mdr_en are never high in the same cycle.

Test Plan:
- Basic fetch, MEM_LAT=1:
  - Stimulus: base=0x010; memory returns A,B,C,D for addresses 0x010..0x013; attached MDR.
  - Required: mem_rd at ack+1, +3, +5, +7 with addresses 0x010..0x013; mdr_en 1000/0100/0010/0001 at ack+2, +4, +6, +8; done at ack+9; MDR=0xABCD; busy low at ack+10.
- MEM_LAT=3, base=0x200, data 1,2,3,4:
  - Required: each mdr_en asserted exactly 3 cycles after its mem_rd; done at ack+17; MDR=0x1234.
- Wrap: base=0xFFE.
  - Required: addresses 0xFFE, 0xFFF, 0x000, 0x001 in that order.
- Abort: MEM_LAT=1, base=0x040; abort=1 in the second ISSUE cycle (ack+3).
  - Required: IDLE at ack+4, busy=0, no done, no further mem_rd; MDR holds only nibble 0 written.
  - Also: abort and req together in IDLE give ack=0 and state stays IDLE.
- req held high continuously, base changed mid-fetch:
  - Required: base change has no effect on mem_addr; second ack exactly 10 cycles after the first (MEM_LAT=1); two done pulses 10 cycles apart.
- reset_n pulsed low in WAIT (MEM_LAT=3):
  - Required: outputs 0 immediately and asynchronously; after release, state is IDLE and a new req fetches correctly.

Source files
------------

// File: rtl/mdr_fetch_ctrl.sv
// mdr_fetch_ctrl: assembles one 16-bit MDR word from a 4-bit-wide memory with
// four nibble reads (base..base+3, big-endian: base lands in MDR[15:12]).
// Latency: done pulses 4*(MEM_LAT+1)+1 cycles after the ack cycle.
// Backpressure: req is only sampled in IDLE; req/base_addr are ignored while busy.
//
// Ports:
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   req_i             fetch request (level), accepted in IDLE when abort_i=0
//   base_addr_i       nibble address of the most-significant nibble, captured on ack
//   abort_i           synchronous cancel; returns to IDLE without done
//   ack_o             combinational acceptance strobe
//   mem_rd_o          one-cycle read strobe per nibble
//   mem_addr_o        read address, valid with mem_rd_o, holds otherwise
//   mdr_en_o          one-hot MDR nibble enable (1000 = [15:12])
//   busy_o            high in every state except IDLE
//   done_o            one-cycle pulse after the fourth nibble is latched
module mdr_fetch_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1     // legal range 1..7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              abort_i,
    output logic              ack_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mdr_en_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_LATCH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic              mem_rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mdr_en_q;
    logic              busy_q;
    logic              done_q;

    // Acceptance is the only Mealy output; req is ignored while reset is held.
    assign ack_o = reset_n && (state_q == S_IDLE) && req_i && !abort_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        case (state_q)
            S_IDLE: begin
                if (req_i && !abort_i) begin
                    base_d  = base_addr_i;
                    idx_d   = 2'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = (MEM_LAT > 1) ? S_WAIT : S_LATCH;
            end
            S_WAIT: begin
                // Counter is loaded with MEM_LAT-1, so leaving on the 1->0 step
                // yields exactly MEM_LAT-1 WAIT cycles.
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides any transition out of a non-IDLE state; the current
        // cycle's outputs were already registered, so an abort in LATCH still
        // writes its nibble.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
        end
    end

    // Outputs are registered from the next state so they are pure decodes of
    // the state the machine is in during that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= 3'd0;
            base_q     <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            mdr_en_q   <= 4'b0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            mem_rd_q <= (state_d == S_ISSUE);
            if (state_d == S_ISSUE) begin
                // Wraps modulo 2^ADDR_W by construction.
                mem_addr_q <= base_d + ADDR_W'(idx_d);
            end
            mdr_en_q <= (state_d == S_LATCH) ? (4'b1000 >> idx_d) : 4'b0000;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign mem_rd_o   = mem_rd_q;
    assign mem_addr_o = mem_addr_q;
    assign mdr_en_o   = mdr_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule
